// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment encoding for the seven-segment scan driver.
package seg7_pkg;

    localparam int SEG_W = 7;

    // Bit positions inside the {a,b,c,d,e,f,g} segment vector.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    function automatic logic [SEG_W-1:0] hex7_encode(input logic [3:0] nib);
        logic [SEG_W-1:0] seg;
        seg = 7'b0000000;
        case (nib)
            4'h0:    seg = 7'b1111110;
            4'h1:    seg = 7'b0110000;
            4'h2:    seg = 7'b1101101;
            4'h3:    seg = 7'b1111001;
            4'h4:    seg = 7'b0110011;
            4'h5:    seg = 7'b1011011;
            4'h6:    seg = 7'b1011111;
            4'h7:    seg = 7'b1110000;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1111011;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b0011111;
            4'hC:    seg = 7'b0001101;
            4'hD:    seg = 7'b0111101;
            4'hE:    seg = 7'b1001111;
            4'hF:    seg = 7'b1000111;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder, active-high segments {a..g}.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    assign seg = hex7_encode(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: frame-synchronous shadow registers,
// digit scan with brightness PWM, leading-zero suppression and registered pins.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lzs_en,
    input  logic [3:0]              brightness,
    input  logic                    enable,
    output logic [SEG_W-1:0]        leds,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_tick
);

    localparam int PRE_CNT = REFRESH_DIV / 16;
    localparam int PW      = (PRE_CNT > 1) ? $clog2(PRE_CNT) : 1;
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0]         PRE_LAST = PW'(PRE_CNT - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [SEG_W-1:0]      SEG_OFF  = SEG_ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;

    logic [PW-1:0]           pre_r;
    logic [3:0]              sub_r;
    logic [IW-1:0]           idx_r;
    logic [4*NUM_DIGITS-1:0] pend_val_r, act_val_r;
    logic [NUM_DIGITS-1:0]   pend_dp_r, act_dp_r;
    logic [NUM_DIGITS-1:0]   pend_blank_r, act_blank_r;
    logic [NUM_DIGITS-1:0]   anode_r;
    logic [SEG_W-1:0]        leds_r;
    logic                    dp_r;
    logic                    ft_r;

    logic                    pre_tc_s;
    logic                    slot_end_s;
    logic                    boundary_s;
    logic                    zero_run_s;
    logic [NUM_DIGITS-1:0]   lzs_mask_s;
    logic [3:0]              nib_s;
    logic [SEG_W-1:0]        seg_s;
    logic                    dark_s;

    assign pre_tc_s   = (pre_r == PRE_LAST);
    assign slot_end_s = pre_tc_s && (sub_r == 4'd15);
    assign boundary_s = slot_end_s && (idx_r == IDX_LAST);

    // Scan timing: prescaler, 16-step subslot counter and digit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_r <= {PW{1'b0}};
            sub_r <= 4'd0;
            idx_r <= {IW{1'b0}};
        end else begin
            if (pre_tc_s) begin
                pre_r <= {PW{1'b0}};
                sub_r <= sub_r + 4'd1;
            end else begin
                pre_r <= pre_r + PW'(1);
                sub_r <= sub_r;
            end
            if (slot_end_s) begin
                idx_r <= (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IW'(1);
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Shadow registers: loads land in pending; active only changes on a frame boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_val_r   <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_r    <= {NUM_DIGITS{1'b0}};
            pend_blank_r <= {NUM_DIGITS{1'b0}};
            act_val_r    <= {(4*NUM_DIGITS){1'b0}};
            act_dp_r     <= {NUM_DIGITS{1'b0}};
            act_blank_r  <= {NUM_DIGITS{1'b0}};
        end else begin
            if (load) begin
                pend_val_r   <= value;
                pend_dp_r    <= dp_in;
                pend_blank_r <= blank_in;
            end else begin
                pend_val_r   <= pend_val_r;
                pend_dp_r    <= pend_dp_r;
                pend_blank_r <= pend_blank_r;
            end
            // A load coinciding with the boundary bypasses pending so it is not lost for a frame.
            if (boundary_s && load) begin
                act_val_r   <= value;
                act_dp_r    <= dp_in;
                act_blank_r <= blank_in;
            end else if (boundary_s) begin
                act_val_r   <= pend_val_r;
                act_dp_r    <= pend_dp_r;
                act_blank_r <= pend_blank_r;
            end else begin
                act_val_r   <= act_val_r;
                act_dp_r    <= act_dp_r;
                act_blank_r <= act_blank_r;
            end
        end
    end

    // Leading-zero mask: a digit is suppressed while it and all higher digits are zero without dp.
    always_comb begin
        zero_run_s = 1'b1;
        lzs_mask_s = {NUM_DIGITS{1'b0}};
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run_s    = zero_run_s & (act_val_r[4*k +: 4] == 4'h0) & ~act_dp_r[k];
            lzs_mask_s[k] = lzs_en & zero_run_s & (k != 0);
        end
    end

    assign nib_s  = act_val_r[{idx_r, 2'b00} +: 4];
    assign dark_s = ~enable | act_blank_r[idx_r] | lzs_mask_s[idx_r] | (sub_r > brightness);

    seg7_hex_decode u_decode (
        .nibble (nib_s),
        .seg    (seg_s)
    );

    // Registered pins: a single register stage keeps anode glitch-free and never multi-hot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode_r <= AN_OFF;
            leds_r  <= SEG_OFF;
            dp_r    <= DP_OFF;
            ft_r    <= 1'b0;
        end else begin
            ft_r <= boundary_s;
            if (dark_s) begin
                anode_r <= AN_OFF;
                leds_r  <= SEG_OFF;
                dp_r    <= DP_OFF;
            end else begin
                anode_r <= (AN_ONE << idx_r) ^ AN_OFF;
                leds_r  <= seg_s ^ SEG_OFF;
                dp_r    <= act_dp_r[idx_r] ^ DP_OFF;
            end
        end
    end

    assign anode      = anode_r;
    assign leds       = leds_r;
    assign dp         = dp_r;
    assign frame_tick = ft_r;

endmodule
